// File: rtl/noc_link_pkg.sv
// rtl/noc_link_pkg.sv - shared types for the NoC credit-link endpoints
package noc_link_pkg;

   localparam int TDATA_W = 32;
   localparam int TDEST_W = 4;
   localparam int TID_W   = 2;
   localparam int DEST_W  = TDEST_W + TID_W;

   typedef enum logic {
      ASSEMBLE = 1'b0,
      HOLD     = 1'b1
   } rx_state_e;

   typedef struct packed {
      logic [TDATA_W-1:0] data;
      logic [DEST_W-1:0]  dest;
      logic               is_tail;
   } flit_entry_t;

   typedef struct packed {
      logic [TID_W-1:0]   tid;
      logic [TDEST_W-1:0] tdest;
   } dest_split_t;

   // Flit destinations travel packed as {tid, tdest}.
   function automatic dest_split_t split_dest(input logic [DEST_W-1:0] dest);
      dest_split_t s;
      s.tid   = dest[DEST_W-1:TDEST_W];
      s.tdest = dest[TDEST_W-1:0];
      return s;
   endfunction

endpackage

// File: rtl/noc_flit_rx_deserializer_if.sv
// rtl/noc_flit_rx_deserializer_if.sv - flit link input and AXIS output bundle
interface noc_flit_rx_deserializer_if #(
   parameter int TDATA_WIDTH          = 32,
   parameter int TDEST_WIDTH          = 4,
   parameter int TID_WIDTH            = 2,
   parameter int SERIALIZATION_FACTOR = 1
);
   localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
   localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;

   logic                   send_in;
   logic [FLIT_WIDTH-1:0]  data_in;
   logic [DEST_WIDTH-1:0]  dest_in;
   logic                   is_tail_in;
   logic                   credit_out;
   logic                   axis_out_tvalid;
   logic                   axis_out_tready;
   logic [TDATA_WIDTH-1:0] axis_out_tdata;
   logic                   axis_out_tlast;
   logic [TID_WIDTH-1:0]   axis_out_tid;
   logic [TDEST_WIDTH-1:0] axis_out_tdest;

   modport master (
      output send_in, data_in, dest_in, is_tail_in, axis_out_tready,
      input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
             axis_out_tid, axis_out_tdest
   );

   modport slave (
      input  send_in, data_in, dest_in, is_tail_in, axis_out_tready,
      output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
             axis_out_tid, axis_out_tdest
   );

endinterface

// File: rtl/noc_flit_rx_deserializer_fifo.sv
// rtl/noc_flit_rx_deserializer_fifo.sv - noc_flit_fifo: synchronous FIFO with count, full and empty
module noc_flit_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_ok, rd_ok;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign rd_ok     = rd_en_i && !empty_o;
   // A write into a full FIFO only lands when a read frees the slot in the same cycle.
   assign wr_ok     = wr_en_i && (!full_o || rd_ok);

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_ok && !rd_ok)      count_q <= count_q + 1'b1;
         else if (!wr_ok && rd_ok) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/noc_flit_rx_deserializer.sv
// rtl/noc_flit_rx_deserializer.sv - credit-link flit receiver reassembling flits into AXIS beats
// Optional sticky overflow flag and occupancy checks under NOC_RX_OVERFLOW_CHECK_EN.
module noc_flit_rx_deserializer
   import noc_link_pkg::*;
#(
   parameter int TDATA_WIDTH          = 32,
   parameter int TDEST_WIDTH          = 4,
   parameter int TID_WIDTH            = 2,
   parameter int SERIALIZATION_FACTOR = 1,
   parameter int FLIT_BUFFER_DEPTH    = 4
) (
   input  logic                        clk_noc,
   input  logic                        rst_n,
   noc_flit_rx_deserializer_if.slave   link,
   output logic                        overflow_err
);
   localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
   localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;
   localparam int CNT_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam int OCC_W      = $clog2(FLIT_BUFFER_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SERIALIZATION_FACTOR - 1);

   typedef struct packed {
      logic [FLIT_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  is_tail;
   } entry_t;

   entry_t                 wr_entry, rd_entry;
   logic                   fifo_empty, fifo_full, pop;
   logic [OCC_W-1:0]       fifo_count;
   rx_state_e              state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [TDATA_WIDTH-1:0] asm_q, word_d, tdata_q;
   logic [DEST_WIDTH-1:0]  asm_dest_q, dest_d, out_dest_q;
   logic                   hold_tail_q, tvalid_q, tlast_q, credit_q;
   logic                   accept, out_free, word_done;

   assign wr_entry = '{data: link.data_in, dest: link.dest_in, is_tail: link.is_tail_in};

   noc_flit_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FLIT_BUFFER_DEPTH)
   ) u_fifo (
      .clk_i     (clk_noc),
      .rst_ni    (rst_n),
      .wr_en_i   (link.send_in),
      .wr_data_i (wr_entry),
      .rd_en_i   (pop),
      .rd_data_o (rd_entry),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign pop       = !fifo_empty && (state_q == ASSEMBLE);
   assign accept    = tvalid_q && link.axis_out_tready;
   assign out_free  = !tvalid_q || accept;
   assign word_done = pop && ((cnt_q == LAST_SLOT) || rd_entry.is_tail);

   // Starting each word from zero leaves the unfilled upper slices of a short packet clear.
   always_comb begin
      word_d = (cnt_q == '0) ? '0 : asm_q;
      word_d[int'(cnt_q)*FLIT_WIDTH +: FLIT_WIDTH] = rd_entry.data;
      dest_d = (cnt_q == '0) ? rd_entry.dest : asm_dest_q;
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ASSEMBLE;
         cnt_q       <= '0;
         asm_q       <= '0;
         asm_dest_q  <= '0;
         hold_tail_q <= 1'b0;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         out_dest_q  <= '0;
         tlast_q     <= 1'b0;
         credit_q    <= 1'b0;
      end else begin
         credit_q <= pop;
         if (accept) tvalid_q <= 1'b0;
         if (state_q == ASSEMBLE) begin
            if (pop && !word_done) begin
               asm_q      <= word_d;
               asm_dest_q <= dest_d;
               cnt_q      <= cnt_q + 1'b1;
            end else if (word_done && out_free) begin
               tvalid_q   <= 1'b1;
               tdata_q    <= word_d;
               out_dest_q <= dest_d;
               tlast_q    <= rd_entry.is_tail;
               cnt_q      <= '0;
            end else if (word_done) begin
               asm_q       <= word_d;
               asm_dest_q  <= dest_d;
               hold_tail_q <= rd_entry.is_tail;
               cnt_q       <= '0;
               state_q     <= HOLD;
            end
         end else if (accept) begin
            tvalid_q   <= 1'b1;
            tdata_q    <= asm_q;
            out_dest_q <= asm_dest_q;
            tlast_q    <= hold_tail_q;
            state_q    <= ASSEMBLE;
         end
      end
   end

   assign link.credit_out      = credit_q;
   assign link.axis_out_tvalid = tvalid_q;
   assign link.axis_out_tdata  = tdata_q;
   assign link.axis_out_tlast  = tlast_q;

   // The shared helper only fits the package's default widths; other widths slice directly.
   if (TDEST_WIDTH == TDEST_W && TID_WIDTH == TID_W) begin : g_pkg_split
      dest_split_t split;
      assign split               = split_dest(out_dest_q);
      assign link.axis_out_tid   = split.tid;
      assign link.axis_out_tdest = split.tdest;
   end else begin : g_slice_split
      assign link.axis_out_tid   = out_dest_q[DEST_WIDTH-1:TDEST_WIDTH];
      assign link.axis_out_tdest = out_dest_q[TDEST_WIDTH-1:0];
   end

`ifdef NOC_RX_OVERFLOW_CHECK_EN
   logic ovf_q;
   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else if (link.send_in && fifo_full && !pop) ovf_q <= 1'b1;
   end
   assign overflow_err = ovf_q;
`ifndef SYNTHESIS
   always_ff @(posedge clk_noc) begin
      if (rst_n) begin
         assert (!(link.send_in && fifo_full && !pop))
            else $error("noc_flit_rx_deserializer: flit written to a full buffer");
         assert (fifo_count <= OCC_W'(FLIT_BUFFER_DEPTH))
            else $error("noc_flit_rx_deserializer: occupancy above credit count");
      end
   end
`endif
`else
   logic unused_count;
   assign unused_count = ^fifo_count;
   assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_rx_deserializer.sv
// tb/tb_noc_flit_rx_deserializer.sv - bench for SF=1 and SF=4 receivers against a packet-level model
module tb_noc_flit_rx_deserializer;

   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  dest;
      logic        tail;
   } flit_t;

`ifdef NOC_RX_OVERFLOW_CHECK_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   logic clk_noc = 1'b0;
   logic rst_n   = 1'b0;
   always #5 clk_noc = ~clk_noc;

   logic        sel = 1'b0;
   logic        d_send = 1'b0, d_tail = 1'b0, d_ready = 1'b1;
   logic [31:0] d_data = '0;
   logic [5:0]  d_dest = '0;
   logic        ovf1, ovf4;

   noc_flit_rx_deserializer_if #(.SERIALIZATION_FACTOR(1)) l1 ();
   noc_flit_rx_deserializer_if #(.SERIALIZATION_FACTOR(4)) l4 ();

   noc_flit_rx_deserializer #(.SERIALIZATION_FACTOR(1)) u_dut1 (
      .clk_noc(clk_noc), .rst_n(rst_n), .link(l1.slave), .overflow_err(ovf1));
   noc_flit_rx_deserializer #(.SERIALIZATION_FACTOR(4)) u_dut4 (
      .clk_noc(clk_noc), .rst_n(rst_n), .link(l4.slave), .overflow_err(ovf4));

   assign l1.send_in         = d_send && !sel;
   assign l1.data_in         = d_data;
   assign l1.dest_in         = d_dest;
   assign l1.is_tail_in      = d_tail;
   assign l1.axis_out_tready = sel ? 1'b1 : d_ready;
   assign l4.send_in         = d_send && sel;
   assign l4.data_in         = d_data[7:0];
   assign l4.dest_in         = d_dest;
   assign l4.is_tail_in      = d_tail;
   assign l4.axis_out_tready = sel ? d_ready : 1'b1;

   logic        m_tvalid, m_tlast, m_credit, m_ovf;
   logic [31:0] m_tdata;
   logic [1:0]  m_tid;
   logic [3:0]  m_tdest;
   assign m_tvalid = sel ? l4.axis_out_tvalid : l1.axis_out_tvalid;
   assign m_tlast  = sel ? l4.axis_out_tlast  : l1.axis_out_tlast;
   assign m_credit = sel ? l4.credit_out      : l1.credit_out;
   assign m_tdata  = sel ? l4.axis_out_tdata  : l1.axis_out_tdata;
   assign m_tid    = sel ? l4.axis_out_tid    : l1.axis_out_tid;
   assign m_tdest  = sel ? l4.axis_out_tdest  : l1.axis_out_tdest;
   assign m_ovf    = sel ? ovf4 : ovf1;

   int          cred1 = 0, cred4 = 0;
   logic [38:0] got1[$], got4[$];
   always @(posedge clk_noc) begin
      if (l1.credit_out) cred1 <= cred1 + 1;
      if (l4.credit_out) cred4 <= cred4 + 1;
      if (l1.axis_out_tvalid && l1.axis_out_tready)
         got1.push_back({l1.axis_out_tlast, l1.axis_out_tid, l1.axis_out_tdest, l1.axis_out_tdata});
      if (l4.axis_out_tvalid && l4.axis_out_tready)
         got4.push_back({l4.axis_out_tlast, l4.axis_out_tid, l4.axis_out_tdest, l4.axis_out_tdata});
   end

   int          n_pass = 0, n_total = 0, n_fail = 0;
   flit_t       sent[$];
   logic [38:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_noc);
   endtask

   task automatic do_reset();
      d_send = 1'b0; d_ready = 1'b1;
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic drive(input logic [31:0] data, input logic [5:0] dest, input logic tail);
      d_send = 1'b1; d_data = data; d_dest = dest; d_tail = tail;
      tick(1);
      d_send = 1'b0;
   endtask

   function automatic int got_size(input bit s);
      return s ? got4.size() : got1.size();
   endfunction

   function automatic logic [38:0] got_at(input bit s, input int i);
      if (s) return (i < got4.size()) ? got4[i] : '0;
      return (i < got1.size()) ? got1[i] : '0;
   endfunction

   task automatic wait_beats(input bit s, input int target, input string tag);
      int c = 0;
      while (got_size(s) < target && c < 500) begin tick(1); c++; end
      check(tag, got_size(s), target);
   endtask

   // Packet-level reference: fill slices low-to-high, close a word when full or on a tail.
   task automatic model(input int sf);
      int          idx = 0;
      logic [31:0] w = '0;
      logic [5:0]  d = '0;
      int          fw = 32 / sf;
      exp_q.delete();
      foreach (sent[i]) begin
         if (idx == 0) begin w = '0; d = sent[i].dest; end
         w = w | ((sent[i].data & ((fw == 32) ? 32'hFFFF_FFFF : ((32'd1 << fw) - 1))) << (fw * idx));
         idx++;
         if (idx == sf || sent[i].tail) begin
            exp_q.push_back({sent[i].tail, d, w});
            idx = 0;
         end
      end
   endtask

   task automatic run_random(input bit s, input int nflits);
      int    base_got, base_cred, sent_n, cyc, back;
      flit_t f;
      sel = s;
      do_reset();
      sent.delete();
      base_got = got_size(s);
      base_cred = s ? cred4 : cred1;
      sent_n = 0; cyc = 0;
      while (sent_n < nflits && cyc < 20000) begin
         back = (s ? cred4 : cred1) - base_cred;
         d_ready = ($urandom_range(3) != 0);
         if ((sent_n - back) < 4 && $urandom_range(1) == 1) begin
            f.data = s ? ($urandom & 32'hFF) : $urandom;
            f.dest = 6'($urandom);
            f.tail = s ? ($urandom_range(3) == 0) : 1'($urandom_range(1));
            if (sent_n == nflits - 1) f.tail = 1'b1;
            d_send = 1'b1; d_data = f.data; d_dest = f.dest; d_tail = f.tail;
            sent.push_back(f);
            sent_n++;
         end else begin
            d_send = 1'b0;
         end
         tick(1); cyc++;
      end
      d_send = 1'b0; d_ready = 1'b1;
      model(s ? 4 : 1);
      wait_beats(s, base_got + exp_q.size(), s ? "rand4_beat_count" : "rand1_beat_count");
      foreach (exp_q[i])
         check(s ? "rand4_beat" : "rand1_beat", got_at(s, base_got + i), exp_q[i]);
      tick(3);
      check(s ? "rand4_credits" : "rand1_credits", (s ? cred4 : cred1) - base_cred, nflits);
   endtask

   initial begin
      int base_got, base_cred;
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_got, base_cred;
      // Reset state, checked while reset is held and after release.
      tick(2);
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         check("rst_tvalid", m_tvalid, 1'b0);
         check("rst_tdata", m_tdata, 32'h0);
         check("rst_meta", {m_tlast, m_tid, m_tdest, m_credit, m_ovf}, 9'h0);
      end
      sel = 1'b0;
      do_reset();

      // SF=1 single-flit latency.
      drive(32'hDEAD_BEEF, 6'b10_0101, 1'b1);
      check("lat_n1_tvalid", m_tvalid, 1'b0);
      check("lat_n1_credit", m_credit, 1'b0);
      tick(1);
      check("lat_tvalid", m_tvalid, 1'b1);
      check("lat_tdata", m_tdata, 32'hDEAD_BEEF);
      check("lat_tid_tdest_tlast", {m_tid, m_tdest, m_tlast}, {2'd2, 4'd5, 1'b1});
      check("lat_credit", m_credit, 1'b1);
      tick(1);
      check("lat_credit_pulse", m_credit, 1'b0);
      check("lat_tvalid_drop", m_tvalid, 1'b0);

      // SF=4 full word, then a short packet, then a fresh word.
      sel = 1'b1;
      base_got = got_size(1'b1); base_cred = cred4;
      drive(32'h11, 6'b01_0111, 1'b0);
      drive(32'h22, 6'h3F, 1'b0);
      drive(32'h33, 6'h3F, 1'b0);
      drive(32'h44, 6'h3F, 1'b1);
      wait_beats(1'b1, base_got + 1, "sf4_word_count");
      check("sf4_word", got_at(1'b1, base_got), {1'b1, 6'b01_0111, 32'h4433_2211});
      drive(32'hAA, 6'h12, 1'b0);
      drive(32'hBB, 6'h00, 1'b1);
      drive(32'h01, 6'h2C, 1'b0);
      drive(32'h02, 6'h00, 1'b0);
      drive(32'h03, 6'h00, 1'b0);
      drive(32'h04, 6'h00, 1'b0);
      wait_beats(1'b1, base_got + 3, "sf4_short_count");
      check("sf4_short", got_at(1'b1, base_got + 1), {1'b1, 6'h12, 32'h0000_BBAA});
      check("sf4_fresh", got_at(1'b1, base_got + 2), {1'b0, 6'h2C, 32'h0403_0201});
      tick(2);
      check("sf4_credits", cred4 - base_cred, 10);

      // SF=1 output stall: one beat held in the output, one in HOLD, two queued.
      sel = 1'b0; d_ready = 1'b0;
      base_got = got_size(1'b0); base_cred = cred1;
      for (int i = 0; i < 4; i++) drive(32'hC0DE_0000 + i, 6'(i), 1'(i == 3));
      tick(8);
      check("stall_tvalid", m_tvalid, 1'b1);
      check("stall_tdata", m_tdata, 32'hC0DE_0000);
      check("stall_credits", cred1 - base_cred, 2);
      check("stall_occupancy", u_dut1.u_fifo.count_o, 3'd2);
      tick(3);
      check("stall_stable", {m_tvalid, m_tlast, m_tid, m_tdest, m_tdata}, {1'b1, 1'b0, 6'd0, 32'hC0DE_0000});
      d_ready = 1'b1;
      wait_beats(1'b0, base_got + 4, "stall_beat_count");
      for (int i = 0; i < 4; i++)
         check("stall_beat", got_at(1'b0, base_got + i), {1'(i == 3), 6'(i), 32'hC0DE_0000 + i});
      tick(2);
      check("stall_credits_total", cred1 - base_cred, 4);

      // Sender ignoring credits: the seventh flit finds the buffer full and is dropped.
      do_reset();
      d_ready = 1'b0;
      base_got = got_size(1'b0); base_cred = cred1;
      for (int i = 0; i < 7; i++) drive(32'hF100_0000 + i, 6'h11, 1'b1);
      tick(2);
      check("ovf_flag", m_ovf, EXP_OVF);
      check("ovf_occupancy", u_dut1.u_fifo.count_o, 3'd4);
      d_ready = 1'b1;
      wait_beats(1'b0, base_got + 6, "ovf_beat_count");
      check("ovf_last_beat", got_at(1'b0, base_got + 5), {1'b1, 6'h11, 32'hF100_0005});
      tick(10);
      check("ovf_no_extra_beat", got_size(1'b0), base_got + 6);
      check("ovf_credits", cred1 - base_cred, 6);
      check("ovf_flag_sticky", m_ovf, EXP_OVF);

      // Asynchronous reset in the middle of a stalled stream.
      d_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive(32'h5A5A_0000 + i, 6'h3F, 1'b1);
      tick(1);
      check("mid_pre_tvalid", m_tvalid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", m_tvalid, 1'b0);
      check("mid_rst_payload", {m_tlast, m_tid, m_tdest, m_tdata}, 39'h0);
      check("mid_rst_credit_ovf", {m_credit, m_ovf}, 2'b00);
      tick(2);
      rst_n = 1'b1;
      base_got = got_size(1'b0); base_cred = cred1;
      d_ready = 1'b1;
      tick(6);
      check("mid_discard_beats", got_size(1'b0), base_got);
      check("mid_discard_credits", cred1 - base_cred, 0);

      run_random(1'b0, 150);
      run_random(1'b1, 200);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
